// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor slice.
//   DEFAULT_WIDTH : default operand width, the same default the ripple-carry adder uses
//   state_t       : sequencer state type, with the IDLE and RUN encodings
package serial_subtractor_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef logic [0:0] state_t;

   localparam state_t IDLE = 1'b0;
   localparam state_t RUN  = 1'b1;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the serial subtractor.
//   master : drives start, A, B and b_in; observes busy, done, D, b_out and ovf
//   slave  : the subtractor side of the bundle
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] D;
   logic             b_out;
   logic             ovf;

   modport master (
      output start, A, B, b_in,
      input  busy, done, D, b_out, ovf
   );

   modport slave (
      input  start, A, B, b_in,
      output busy, done, D, b_out, ovf
   );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor, purely combinational.
//   a, b   : minuend and subtrahend bits
//   br_in  : borrow into this bit
//   d      : difference bit
//   br_out : borrow out of this bit
module serial_subtractor_full_subtractor (
   input  logic a,
   input  logic b,
   input  logic br_in,
   output logic d,
   output logic br_out
);

   assign d      = a ^ b ^ br_in;
   assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - b_in, one bit per clock, LSB first.
//   clk : clock; all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : start/A/B/b_in request and busy/done/D/b_out/ovf result, through the slave modport
// The operands are captured on an accepted start. Each RUN edge consumes one bit. D, b_out and
// ovf update only at completion, together with a one-cycle done pulse.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             br_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] d_q;
   logic             b_out_q;
   logic             ovf_q;
   logic             done_q;

   logic d_bit;
   logic br_next;
   logic last_bit;

   // The operand registers shift right, so bit 0 is always the bit being processed.
   serial_subtractor_full_subtractor u_fs (
      .a      (a_q[0]),
      .b      (b_q[0]),
      .br_in  (br_q),
      .d      (d_bit),
      .br_out (br_next)
   );

   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         d_q     <= '0;
         b_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.A;
                  b_q     <= bus.B;
                  br_q    <= bus.b_in;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               res_q <= {d_bit, res_q[WIDTH-1:1]};
               br_q  <= br_next;
               cnt_q <= cnt_q + 1'b1;
               if (last_bit) begin
                  d_q     <= {d_bit, res_q[WIDTH-1:1]};
                  b_out_q <= br_next;
                  // On the last bit, a_q[0]/b_q[0] are the captured operand sign bits.
                  ovf_q   <= (a_q[0] != b_q[0]) && (d_bit != a_q[0]);
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy  = (state_q == RUN);
   assign bus.done  = done_q;
   assign bus.D     = d_q;
   assign bus.b_out = b_out_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor, with a WIDTH=4 and a WIDTH=8 instance.
// Expected results are queued when a request is issued. A monitor per instance pops one
// expected result on each done pulse and compares it with the outputs.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(4)) bus4 ();
   serial_subtractor_if #(.WIDTH(8)) bus8 ();

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Each entry is packed as {D, b_out, ovf}.
   logic [5:0] q4[$];
   logic [9:0] q8[$];
   logic [5:0] e4;
   logic [9:0] e8;
   logic       prev_done4 = 1'b0;
   logic       prev_done8 = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitors
   always @(negedge clk) begin
      if (bus4.done === 1'b1) begin
         check("done4_one_cycle", prev_done4, 0);
         n_checks++;
         if (q4.size() == 0) begin
            n_fail++;
            $display("FAIL done4_unexpected: got done=1, expected no completion");
         end else begin
            e4 = q4.pop_front();
            check("D4", bus4.D, e4[5:2]);
            check("b_out4", bus4.b_out, e4[1]);
            check("ovf4", bus4.ovf, e4[0]);
         end
      end
      prev_done4 = bus4.done;
   end

   always @(negedge clk) begin
      if (bus8.done === 1'b1) begin
         check("done8_one_cycle", prev_done8, 0);
         n_checks++;
         if (q8.size() == 0) begin
            n_fail++;
            $display("FAIL done8_unexpected: got done=1, expected no completion");
         end else begin
            e8 = q8.pop_front();
            check("D8", bus8.D, e8[9:2]);
            check("b_out8", bus8.b_out, e8[1]);
            check("ovf8", bus8.ovf, e8[0]);
         end
      end
      prev_done8 = bus8.done;
   end

   // Waits (bounded) for done, counting busy cycles on the way, then leaves the done cycle.
   task automatic wait_done4(input int exp_busy);
      int nb = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus4.done === 1'b1) seen = 1'b1;
         else if (bus4.busy === 1'b1) nb++;
      end
      check("done4_seen", 32'(seen), 1);
      check("busy4_cycles", nb, exp_busy);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done8(input int exp_busy);
      int nb = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (bus8.done === 1'b1) seen = 1'b1;
         else if (bus8.busy === 1'b1) nb++;
      end
      check("done8_seen", 32'(seen), 1);
      check("busy8_cycles", nb, exp_busy);
      @(posedge clk);
      #1;
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                      input logic [3:0] d, input logic bo, input logic ov);
      bus4.start = 1'b1;
      bus4.A     = a;
      bus4.B     = b;
      bus4.b_in  = bin;
      q4.push_back({d, bo, ov});
      @(posedge clk);
      #1;
      bus4.start = 1'b0;
      wait_done4(4);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] d, input logic bo, input logic ov);
      bus8.start = 1'b1;
      bus8.A     = a;
      bus8.B     = b;
      bus8.b_in  = bin;
      q8.push_back({d, bo, ov});
      @(posedge clk);
      #1;
      bus8.start = 1'b0;
      wait_done8(8);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      n_fail++;
      $fatal(1, "timeout");
   end

   initial begin
      rst        = 1'b1;
      bus4.start = 1'b0;
      bus4.A     = '0;
      bus4.B     = '0;
      bus4.b_in  = 1'b0;
      bus8.start = 1'b0;
      bus8.A     = '0;
      bus8.B     = '0;
      bus8.b_in  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy4", bus4.busy, 0);
      check("rst_done4", bus4.done, 0);
      check("rst_D4", bus4.D, 0);
      check("rst_b_out4", bus4.b_out, 0);
      check("rst_ovf4", bus4.ovf, 0);
      check("rst_D8", bus8.D, 0);
      check("rst_busy8", bus8.busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic, unsigned underflow and signed overflow cases
      op4(4'b0111, 4'b0001, 1'b0, 4'b0110, 1'b0, 1'b0);
      op4(4'b0001, 4'b0111, 1'b0, 4'b1010, 1'b1, 1'b0);
      op4(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
      op4(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
      op4(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);

      // Hold start high and change the operands during RUN; only the captured pair counts.
      bus4.start = 1'b1;
      bus4.A     = 4'b0111;
      bus4.B     = 4'b0001;
      bus4.b_in  = 1'b0;
      q4.push_back({4'b0110, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         bus4.A    = 4'(4'hc + i);
         bus4.B    = 4'(4'h3 + i);
         bus4.b_in = 1'b1;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("busy4_held", bus4.busy, 1);
      @(posedge clk);
      #1;
      // Done cycle: a new request with start still high is accepted at the next edge.
      bus4.A    = 4'b1011;
      bus4.B    = 4'b0101;
      bus4.b_in = 1'b0;
      q4.push_back({4'b0110, 1'b0, 1'b1});
      @(negedge clk);
      check("done4_in_accept_cycle", bus4.done, 1);
      @(posedge clk);
      #1;
      bus4.start = 1'b0;
      @(negedge clk);
      check("busy4_second", bus4.busy, 1);
      check("D4_held_during_run", bus4.D, 4'b0110);
      check("ovf4_held_during_run", bus4.ovf, 0);
      wait_done4(3);

      // Reset on the second RUN edge aborts the operation with no done pulse.
      bus4.start = 1'b1;
      bus4.A     = 4'b0101;
      bus4.B     = 4'b0011;
      @(posedge clk);
      #1;
      bus4.start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy4", bus4.busy, 0);
      check("abort_done4", bus4.done, 0);
      check("abort_D4", bus4.D, 0);
      check("abort_b_out4", bus4.b_out, 0);
      check("abort_ovf4", bus4.ovf, 0);
      repeat (6) @(negedge clk);
      check("abort_no_done4", bus4.done, 0);
      @(posedge clk);
      #1;
      op4(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);

      // Wider instance
      op8(8'h00, 8'h01, 1'b0, 8'hff, 1'b1, 1'b0);
      op8(8'h80, 8'h01, 1'b0, 8'h7f, 1'b0, 1'b1);
      op8(8'h64, 8'h1e, 1'b1, 8'h45, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      check("q4_drained", q4.size(), 0);
      check("q8_drained", q8.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
